memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have no parameters; instruction IDs (INSTR_LB, LH, LW, LBU, LHU, SB, SH, SW) SHALL come from the team's shared instruction-ID header.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 valid_in  in  1  upstream instruction is valid (not a bubble).
REQ-005 rd_valid_in  in  1  instruction writes rd.
REQ-006 rd_addr_in  in  5  destination register.
REQ-007 alu_result_in  in  32  ALU result; this is the effective address for loads and stores.
REQ-008 rs2_data_in  in  32  store data.
REQ-009 instr_id_in  in  6  instruction ID.
REQ-010 stall_out  out  1  upstream SHALL hold its inputs while this is high.
REQ-011 dmem_req, dmem_we  out  1 each  memory request and write enable.
REQ-012 dmem_addr  out  32  word-aligned address; dmem_wdata  out  32  write data; dmem_wstrb  out  4  byte write strobes.
REQ-013 dmem_ack  in  1  request complete; dmem_rdata  in  32  read word, valid in the dmem_ack cycle.
REQ-014 valid_out, rd_valid_out  out  1 each; rd_addr_out  out  5; rd_value_out  out  32; mem_data_out  out  32; instr_id_out  out  6. These form the registered interface to writeback.
REQ-015 misalign_out  out  1  one-cycle pulse on a misaligned access.

Function
REQ-016 The FSM SHALL have two states, IDLE and BUSY; stall_out SHALL equal (state==BUSY), driven combinationally.
REQ-017 A valid non-memory instruction in IDLE SHALL appear on the writeback outputs next cycle with valid_out=1 and rd fields copied.
- rd_value_out = alu_result_in.
- Latency is 1.
REQ-018 An aligned load or store in IDLE SHALL be captured and the FSM SHALL move to BUSY.
- From the next cycle: dmem_req=1, with dmem_addr = {addr[31:2], 2'b00}.
- dmem_we, dmem_wdata and dmem_wstrb SHALL stay stable until dmem_ack is sampled high.
REQ-019 In BUSY with dmem_ack=1, the block SHALL deassert dmem_req next cycle, return to IDLE, and pulse valid_out=1 for one cycle carrying the captured rd/instr fields.
REQ-020 The block SHALL ignore dmem_ack when dmem_req=0.
REQ-021 Load extraction SHALL use off = addr[1:0]:
- LB/LBU: byte at bits [8*off+7 : 8*off], sign- or zero-extended.
- LH/LHU: half at bits [8*off+15 : 8*off], extended.
- LW: the full word.
- The result is registered into mem_data_out.
REQ-022 Store encoding:
- SB: wstrb = 4'b0001<<off, wdata = byte replicated 4 times.
- SH: wstrb = 4'b0011<<off, wdata = half replicated twice.
- SW: wstrb = 4'b1111, wdata = rs2.
REQ-023 For stores and loads, rd_valid_out SHALL equal rd_valid_in (stores are decoded with rd_valid 0).
REQ-024 Misaligned accesses (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL NOT issue dmem_req.
- Next cycle: valid_out=1, rd_valid_out=0, misalign_out=1.
- The FSM stays in IDLE.
REQ-025 valid_out SHALL be 0 in every cycle that does not complete an instruction.
- Other writeback outputs SHALL hold their last values.
- misalign_out SHALL be 0 except in its pulse cycle.
REQ-026 In the dmem_ack cycle stall_out is still 1, so the next instruction SHALL be accepted no earlier than the following cycle.
REQ-027 With valid_in=0 in IDLE, the block SHALL issue no request and leave the FSM unchanged.

Reset
REQ-028 When rst is asserted, the block SHALL asynchronously force:
- state=IDLE;
- valid_out, rd_valid_out, misalign_out, dmem_req, dmem_we, stall_out to 0;
- all data and address outputs and dmem_wstrb to 0.
REQ-029 Reset asserted while in BUSY SHALL abandon the outstanding request with no completion pulse.
- A dmem_ack arriving after reset release SHALL be ignored.

Verification
REQ-030 ADD, rd=5, alu=0x1234 -> next cycle valid_out=1, rd_addr_out=5, rd_value_out=0x1234, and stall_out stays 0.
REQ-031 LB at addr 0x103, dmem_rdata=0x80FF_FFFF, ack after 3 cycles ->
- dmem_addr=0x100 and dmem_req held for 3 cycles;
- mem_data_out=0xFFFF_FF80; valid_out pulses once.
REQ-032 LHU at 0x202 with rdata 0xBEEF_0000 -> mem_data_out=0x0000_BEEF.
REQ-033 SB at 0x41, rs2=0xAB -> dmem_we=1, dmem_wstrb=4'b0010, dmem_wdata=0xABAB_ABAB; after ack, valid_out=1 with rd_valid_out=0.
REQ-034 LW at 0x302 -> no dmem_req; next cycle valid_out=1, rd_valid_out=0, misalign_out=1.
REQ-035 rst asserted in BUSY, then a later dmem_ack -> all outputs 0 immediately and no valid_out pulse.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: load/store unit between execute and writeback.
//   Non-memory instructions pass through to writeback with one cycle of latency.
//   An aligned load or store is captured, and the block issues one dmem request.
//   It holds the upstream stage (stall_out) until dmem_ack arrives.
//   A misaligned access issues no request. It completes at once with
//   misalign_out pulsed and rd_valid_out cleared.
// Ports:
//   clk, rst                  clock, async active-high reset
//   valid_in .. instr_id_in   instruction from execute
//   stall_out                 upstream holds its inputs while high (state==BUSY)
//   dmem_*                    data-memory request/response
//   valid_out .. instr_id_out registered writeback interface
//   misalign_out              one-cycle pulse on a misaligned access
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        rd_valid_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  input  logic [5:0]  instr_id_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic        rd_valid_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_value_out,
  output logic [31:0] mem_data_out,
  output logic [5:0]  instr_id_out,
  output logic        misalign_out
);
  // Shared instruction-ID encoding (mirrors the team instruction-ID header).
  localparam logic [5:0] INSTR_LB  = 6'd1;
  localparam logic [5:0] INSTR_LH  = 6'd2;
  localparam logic [5:0] INSTR_LW  = 6'd3;
  localparam logic [5:0] INSTR_LBU = 6'd4;
  localparam logic [5:0] INSTR_LHU = 6'd5;
  localparam logic [5:0] INSTR_SB  = 6'd6;
  localparam logic [5:0] INSTR_SH  = 6'd7;
  localparam logic [5:0] INSTR_SW  = 6'd8;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state;

  // Fields captured at issue, replayed on completion
  logic [1:0]  r_off;
  logic [5:0]  r_id;
  logic        r_rd_valid;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_addr;

  logic        w_is_load, w_is_store, w_misalign;
  logic [1:0]  w_off;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_shift, w_load;

  assign stall_out = (r_state == BUSY);
  assign w_off     = alu_result_in[1:0];

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_misalign = 1'b0;
    w_wstrb    = 4'b0000;
    w_wdata    = rs2_data_in;
    case (instr_id_in)
      INSTR_LB, INSTR_LBU: w_is_load = 1'b1;
      INSTR_LH, INSTR_LHU: begin
        w_is_load  = 1'b1;
        w_misalign = alu_result_in[0];
      end
      INSTR_LW: begin
        w_is_load  = 1'b1;
        w_misalign = (w_off != 2'b00);
      end
      INSTR_SB: begin
        w_is_store = 1'b1;
        w_wstrb    = 4'b0001 << w_off;
        w_wdata    = {4{rs2_data_in[7:0]}};
      end
      INSTR_SH: begin
        w_is_store = 1'b1;
        w_misalign = alu_result_in[0];
        w_wstrb    = 4'b0011 << w_off;
        w_wdata    = {2{rs2_data_in[15:0]}};
      end
      INSTR_SW: begin
        w_is_store = 1'b1;
        w_misalign = (w_off != 2'b00);
        w_wstrb    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Bring the addressed byte/half down to bit 0, then extend.
  assign w_shift = dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = dmem_rdata;
    case (r_id)
      INSTR_LB:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      INSTR_LBU: w_load = {24'd0, w_shift[7:0]};
      INSTR_LH:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      INSTR_LHU: w_load = {16'd0, w_shift[15:0]};
      default:   w_load = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_off        <= 2'b00;
      r_id         <= 6'd0;
      r_rd_valid   <= 1'b0;
      r_rd_addr    <= 5'd0;
      r_addr       <= 32'd0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_wdata   <= 32'd0;
      dmem_wstrb   <= 4'b0000;
      valid_out    <= 1'b0;
      rd_valid_out <= 1'b0;
      rd_addr_out  <= 5'd0;
      rd_value_out <= 32'd0;
      mem_data_out <= 32'd0;
      instr_id_out <= 6'd0;
      misalign_out <= 1'b0;
    end else begin
      // Completion and misalign are single-cycle pulses
      valid_out    <= 1'b0;
      misalign_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            if ((w_is_load || w_is_store) && w_misalign) begin
              valid_out    <= 1'b1;
              rd_valid_out <= 1'b0;
              misalign_out <= 1'b1;
              rd_addr_out  <= rd_addr_in;
              rd_value_out <= alu_result_in;
              instr_id_out <= instr_id_in;
            end else if (w_is_load || w_is_store) begin
              r_state    <= BUSY;
              r_off      <= w_off;
              r_id       <= instr_id_in;
              r_rd_valid <= rd_valid_in;
              r_rd_addr  <= rd_addr_in;
              r_addr     <= alu_result_in;
              dmem_req   <= 1'b1;
              dmem_we    <= w_is_store;
              dmem_addr  <= {alu_result_in[31:2], 2'b00};
              dmem_wdata <= w_wdata;
              dmem_wstrb <= w_wstrb;
            end else begin
              valid_out    <= 1'b1;
              rd_valid_out <= rd_valid_in;
              rd_addr_out  <= rd_addr_in;
              rd_value_out <= alu_result_in;
              instr_id_out <= instr_id_in;
            end
          end
        end
        BUSY: begin
          // Request fields stay frozen until the ack is seen with req high
          if (dmem_req && dmem_ack) begin
            r_state      <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            valid_out    <= 1'b1;
            rd_valid_out <= r_rd_valid;
            rd_addr_out  <= r_rd_addr;
            rd_value_out <= r_addr;
            instr_id_out <= r_id;
            if (!dmem_we) mem_data_out <= w_load;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  localparam logic [5:0] LB = 6'd1, LH = 6'd2, LW = 6'd3, LBU = 6'd4, LHU = 6'd5;
  localparam logic [5:0] SB = 6'd6, SH = 6'd7, SW = 6'd8, ADD = 6'd20;

  logic clk = 1'b0, rst = 1'b1;
  logic valid_in = 0, rd_valid_in = 0;
  logic [4:0] rd_addr_in = 0;
  logic [31:0] alu_result_in = 0, rs2_data_in = 0;
  logic [5:0] instr_id_in = 0;
  logic stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0] dmem_wstrb;
  logic dmem_ack = 0;
  logic [31:0] dmem_rdata = 0;
  logic valid_out, rd_valid_out, misalign_out;
  logic [4:0] rd_addr_out;
  logic [31:0] rd_value_out, mem_data_out;
  logic [5:0] instr_id_out;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .rd_valid_in(rd_valid_in),
    .rd_addr_in(rd_addr_in), .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
    .instr_id_in(instr_id_in), .stall_out(stall_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .valid_out(valid_out), .rd_valid_out(rd_valid_out), .rd_addr_out(rd_addr_out),
    .rd_value_out(rd_value_out), .mem_data_out(mem_data_out),
    .instr_id_out(instr_id_out), .misalign_out(misalign_out)
  );

  // Present one instruction; the caller releases valid_in after the accepting edge.
  task automatic drive(input logic [5:0] id, input logic rdv, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rs2);
    valid_in = 1; instr_id_in = id; rd_valid_in = rdv; rd_addr_in = rd;
    alu_result_in = alu; rs2_data_in = rs2;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({stall_out, dmem_req, dmem_we, valid_out, rd_valid_out, misalign_out} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl got=%b exp=000000",
        {stall_out, dmem_req, dmem_we, valid_out, rd_valid_out, misalign_out});
    end
    n_cmp++;
    if ({dmem_addr, dmem_wdata, dmem_wstrb, rd_addr_out, rd_value_out, mem_data_out, instr_id_out} !== '0) begin
      n_err++; $display("FAIL reset_data got addr=%h wdata=%h strb=%b rv=%h md=%h exp=0",
        dmem_addr, dmem_wdata, dmem_wstrb, rd_value_out, mem_data_out);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_alu();
    @(negedge clk); drive(ADD, 1, 5'd5, 32'h1234, 32'h0);
    @(posedge clk); #1; valid_in = 0;
    n_cmp++;
    if ({valid_out, rd_valid_out, rd_addr_out, rd_value_out, stall_out, dmem_req} !== {1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL alu_pass got v=%b rdv=%b rd=%0d val=%h stall=%b req=%b exp v=1 rdv=1 rd=5 val=1234 stall=0 req=0",
        valid_out, rd_valid_out, rd_addr_out, rd_value_out, stall_out, dmem_req);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({valid_out, rd_value_out} !== {1'b0, 32'h1234}) begin
      n_err++; $display("FAIL alu_hold got v=%b val=%h exp v=0 val=1234", valid_out, rd_value_out);
    end
  endtask

  // Issue a load, hold the ack off for `wait_cyc` request cycles, then check the extracted data.
  task automatic test_load(input string nm, input logic [5:0] id, input logic [31:0] addr,
                           input logic [31:0] rdata, input int wait_cyc, input logic [31:0] exp);
    int pulses;
    @(negedge clk); drive(id, 1, 5'd9, addr, 32'h0);
    @(posedge clk); #1; valid_in = 0;
    for (int k = 0; k < wait_cyc; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({dmem_req, dmem_we, stall_out, valid_out, dmem_addr} !== {4'b1010, addr & 32'hFFFF_FFFC}) begin
        n_err++; $display("FAIL %s_req[%0d] got req=%b we=%b stall=%b v=%b addr=%h exp 1 0 1 0 %h",
          nm, k, dmem_req, dmem_we, stall_out, valid_out, dmem_addr, addr & 32'hFFFF_FFFC);
      end
      if (k == wait_cyc - 1) begin dmem_ack = 1; dmem_rdata = rdata; end
    end
    @(posedge clk); #1; dmem_ack = 0;
    pulses = valid_out ? 1 : 0;
    n_cmp++;
    if ({valid_out, rd_valid_out, rd_addr_out, mem_data_out, instr_id_out, dmem_req, stall_out} !== {1'b1, 1'b1, 5'd9, exp, id, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL %s_done got v=%b rdv=%b rd=%0d md=%h id=%0d req=%b stall=%b exp md=%h",
        nm, valid_out, rd_valid_out, rd_addr_out, mem_data_out, instr_id_out, dmem_req, stall_out, exp);
    end
    @(posedge clk); #1;
    if (valid_out) pulses++;
    n_cmp++;
    if (pulses !== 1 || mem_data_out !== exp) begin
      n_err++; $display("FAIL %s_pulse got pulses=%0d md=%h exp 1 %h", nm, pulses, mem_data_out, exp);
    end
  endtask

  task automatic test_store(input string nm, input logic [5:0] id, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    @(negedge clk); drive(id, 0, 5'd0, addr, rs2);
    @(posedge clk); #1; valid_in = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({dmem_req, dmem_we, dmem_wstrb, dmem_wdata, dmem_addr} !== {2'b11, exp_strb, exp_wd, addr & 32'hFFFF_FFFC}) begin
        n_err++; $display("FAIL %s_req[%0d] got req=%b we=%b strb=%b wd=%h addr=%h exp strb=%b wd=%h",
          nm, k, dmem_req, dmem_we, dmem_wstrb, dmem_wdata, dmem_addr, exp_strb, exp_wd);
      end
      if (k == 1) dmem_ack = 1;
    end
    @(posedge clk); #1; dmem_ack = 0;
    n_cmp++;
    if ({valid_out, rd_valid_out, instr_id_out, dmem_req} !== {1'b1, 1'b0, id, 1'b0}) begin
      n_err++; $display("FAIL %s_done got v=%b rdv=%b id=%0d req=%b exp v=1 rdv=0 id=%0d req=0",
        nm, valid_out, rd_valid_out, instr_id_out, dmem_req, id);
    end
  endtask

  task automatic test_misalign();
    @(negedge clk); drive(LW, 1, 5'd3, 32'h302, 32'h0);
    @(posedge clk); #1; valid_in = 0;
    n_cmp++;
    if ({dmem_req, stall_out, valid_out, rd_valid_out, misalign_out} !== 5'b00101) begin
      n_err++; $display("FAIL misalign_lw got req=%b stall=%b v=%b rdv=%b mis=%b exp 00101",
        dmem_req, stall_out, valid_out, rd_valid_out, misalign_out);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({dmem_req, valid_out, misalign_out} !== 3'b000) begin
      n_err++; $display("FAIL misalign_after got req=%b v=%b mis=%b exp 000", dmem_req, valid_out, misalign_out);
    end
    @(negedge clk); drive(SH, 0, 5'd0, 32'h43, 32'h1111);
    @(posedge clk); #1; valid_in = 0;
    n_cmp++;
    if ({dmem_req, valid_out, misalign_out} !== 3'b011) begin
      n_err++; $display("FAIL misalign_sh got req=%b v=%b mis=%b exp 011", dmem_req, valid_out, misalign_out);
    end
  endtask

  // Next instruction is held on the inputs during the ack cycle; it must be taken one cycle later.
  task automatic test_back_to_back();
    @(negedge clk); drive(SW, 0, 5'd0, 32'h500, 32'hDEAD_BEEF);
    @(posedge clk); #1; drive(ADD, 1, 5'd7, 32'h77, 32'h0);
    @(negedge clk);
    n_cmp++;
    if ({stall_out, dmem_wstrb, dmem_wdata} !== {1'b1, 4'b1111, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL b2b_sw got stall=%b strb=%b wd=%h exp 1 1111 deadbeef", stall_out, dmem_wstrb, dmem_wdata);
    end
    dmem_ack = 1;
    @(posedge clk); #1; dmem_ack = 0;
    n_cmp++;
    if ({valid_out, rd_valid_out, instr_id_out} !== {1'b1, 1'b0, SW}) begin
      n_err++; $display("FAIL b2b_first got v=%b rdv=%b id=%0d exp 1 0 %0d", valid_out, rd_valid_out, instr_id_out, SW);
    end
    @(posedge clk); #1; valid_in = 0;
    n_cmp++;
    if ({valid_out, instr_id_out, rd_addr_out, rd_value_out} !== {1'b1, ADD, 5'd7, 32'h77}) begin
      n_err++; $display("FAIL b2b_second got v=%b id=%0d rd=%0d val=%h exp 1 %0d 7 77",
        valid_out, instr_id_out, rd_addr_out, rd_value_out, ADD);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({valid_out, dmem_req} !== 2'b00) begin
      n_err++; $display("FAIL idle_no_req got v=%b req=%b exp 00", valid_out, dmem_req);
    end
  endtask

  task automatic test_reset_busy();
    @(negedge clk); drive(LW, 1, 5'd4, 32'h400, 32'h0);
    @(posedge clk); #1; valid_in = 0;
    #3; rst = 1; #1;
    n_cmp++;
    if ({stall_out, dmem_req, dmem_we, valid_out, rd_valid_out, misalign_out, dmem_addr, rd_addr_out, rd_value_out, mem_data_out, instr_id_out} !== '0) begin
      n_err++; $display("FAIL rst_busy got stall=%b req=%b v=%b addr=%h md=%h exp all 0",
        stall_out, dmem_req, valid_out, dmem_addr, mem_data_out);
    end
    @(negedge clk); rst = 0; dmem_ack = 1; dmem_rdata = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({valid_out, dmem_req, stall_out, mem_data_out} !== {3'b000, 32'h0}) begin
        n_err++; $display("FAIL rst_late_ack[%0d] got v=%b req=%b stall=%b md=%h exp 0 0 0 0",
          k, valid_out, dmem_req, stall_out, mem_data_out);
      end
    end
    dmem_ack = 0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load("lb",  LB,  32'h103, 32'h80FF_FFFF, 3, 32'hFFFF_FF80);
    test_load("lhu", LHU, 32'h202, 32'hBEEF_0000, 1, 32'h0000_BEEF);
    test_load("lh",  LH,  32'h200, 32'h0000_8001, 2, 32'hFFFF_8001);
    test_load("lbu", LBU, 32'h101, 32'h0000_9A00, 1, 32'h0000_009A);
    test_load("lw",  LW,  32'h304, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
    test_store("sb", SB, 32'h41, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
    test_store("sh", SH, 32'h42, 32'h1234_5678, 4'b1100, 32'h5678_5678);
    test_misalign();
    test_back_to_back();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
